vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 41 ++++
 rtl/vga_axis_counter.sv | 84 ++++++++
 rtl/vga_timing_gen.sv | 174 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Default 640x480@60 timing constants, axis phase type,
//               total helpers and character-cell geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int c_H_ACTIVE  = 640;
  localparam int c_H_FRONT   = 16;
  localparam int c_H_SYNC    = 96;
  localparam int c_H_BACK    = 48;
  localparam int c_V_ACTIVE  = 480;
  localparam int c_V_FRONT   = 10;
  localparam int c_V_SYNC    = 2;
  localparam int c_V_BACK    = 33;
  localparam int c_MAX_TOTAL = 1024;

  localparam int CELL_W = 8;
  localparam int CELL_H = 12;

  typedef enum logic [1:0] {
    ACT  = 2'd0,
    FP   = 2'd1,
    SYNC = 2'd2,
    BP   = 2'd3
  } phase_t;

  function automatic int h_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int v_total(input int active, input int front,
                                 input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_axis_counter
// Description : One raster axis: counter, ACT/FP/SYNC/BP phase FSM, wrap
//               strobe and registered sync pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int W        = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic         clock50,
  input  logic         reset,
  input  logic         enable,
  input  logic [W-1:0] limit_active,
  input  logic [W-1:0] limit_front,
  input  logic [W-1:0] limit_sync,
  input  logic [W-1:0] limit_back,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap,
  output logic         sync
);

  logic [W-1:0] r_count;
  phase_t       r_phase;
  logic         r_sync;
  logic [W-1:0] w_next_count;
  phase_t       w_next_phase;
  logic         w_wrap;
  logic [W-1:0] w_fp_start;
  logic [W-1:0] w_sync_start;
  logic [W-1:0] w_bp_start;
  logic [W-1:0] w_last;

  assign w_fp_start   = limit_active;
  assign w_sync_start = limit_active + limit_front;
  assign w_bp_start   = w_sync_start + limit_sync;
  assign w_last       = w_bp_start + limit_back - 1'b1;

  always_comb begin
    w_wrap       = enable && (r_count == w_last);
    w_next_count = r_count;
    if (enable) begin
      w_next_count = w_wrap ? '0 : r_count + 1'b1;
    end
  end

  // Phase changes on the edge where the count enters the next region.
  always_comb begin
    w_next_phase = r_phase;
    if (enable) begin
      case (r_phase)
        ACT:     if (w_next_count == w_fp_start)   w_next_phase = FP;
        FP:      if (w_next_count == w_sync_start) w_next_phase = SYNC;
        SYNC:    if (w_next_count == w_bp_start)   w_next_phase = BP;
        BP:      if (w_wrap)                       w_next_phase = ACT;
        default:                                   w_next_phase = ACT;
      endcase
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      r_count <= '0;
      r_phase <= ACT;
      r_sync  <= ~SYNC_POL;
    end else begin
      r_count <= w_next_count;
      r_phase <= w_next_phase;
      r_sync  <= (w_next_phase == SYNC) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign count = r_count;
  // Lookahead phase (state entered on this edge) so parents can register decodes.
  assign phase = w_next_phase;
  assign wrap  = w_wrap;
  assign sync  = r_sync;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing (counters, syncs, blanking, frame pulse)
//               on a divide-by-2 pixel enable. Optional macro
//               VGA_CHAR_CELL_EN adds 8x12 character-cell coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = c_H_ACTIVE,
  parameter int H_FRONT  = c_H_FRONT,
  parameter int H_SYNC   = c_H_SYNC,
  parameter int H_BACK   = c_H_BACK,
  parameter int V_ACTIVE = c_V_ACTIVE,
  parameter int V_FRONT  = c_V_FRONT,
  parameter int V_SYNC   = c_V_SYNC,
  parameter int V_BACK   = c_V_BACK,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clock50,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] HorizontalCounter,
  output logic [9:0] VerticalCounter,
  output logic       HSync,
  output logic       VSync,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_CHAR_CELL_EN
 ,output logic [6:0] char_col,
  output logic [5:0] char_row,
  output logic [3:0] glyph_row
`endif
);

  localparam int c_W       = 10;
  localparam int c_H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int c_V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (c_H_TOTAL > c_MAX_TOTAL) begin : g_h_total_check
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (c_V_TOTAL > c_MAX_TOTAL) begin : g_v_total_check
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  logic   r_pixel_tick;
  logic   r_video_on;
  logic   r_frame_start;
  logic   w_h_wrap;
  logic   w_v_wrap;
  logic   w_video_on_next;
  phase_t w_h_phase_next;
  phase_t w_v_phase_next;

  vga_axis_counter #(.W(c_W), .SYNC_POL(SYNC_POL)) u_h_axis (
    .clock50      (clock50),
    .reset        (reset),
    .enable       (r_pixel_tick),
    .limit_active (c_W'(H_ACTIVE)),
    .limit_front  (c_W'(H_FRONT)),
    .limit_sync   (c_W'(H_SYNC)),
    .limit_back   (c_W'(H_BACK)),
    .count        (HorizontalCounter),
    .phase        (w_h_phase_next),
    .wrap         (w_h_wrap),
    .sync         (HSync)
  );

  vga_axis_counter #(.W(c_W), .SYNC_POL(SYNC_POL)) u_v_axis (
    .clock50      (clock50),
    .reset        (reset),
    .enable       (w_h_wrap),
    .limit_active (c_W'(V_ACTIVE)),
    .limit_front  (c_W'(V_FRONT)),
    .limit_sync   (c_W'(V_SYNC)),
    .limit_back   (c_W'(V_BACK)),
    .count        (VerticalCounter),
    .phase        (w_v_phase_next),
    .wrap         (w_v_wrap),
    .sync         (VSync)
  );

  assign w_video_on_next = (w_h_phase_next == ACT) && (w_v_phase_next == ACT);

  // A vertical wrap sends both counters to 0 on this edge: that is frame start.
  always_ff @(posedge clock50) begin
    if (reset) begin
      r_pixel_tick  <= 1'b0;
      r_video_on    <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_tick  <= ~r_pixel_tick;
      r_video_on    <= w_video_on_next;
      r_frame_start <= w_v_wrap;
    end
  end

  assign pixel_tick  = r_pixel_tick;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;

`ifdef VGA_CHAR_CELL_EN
  logic [2:0] r_cell_x;
  logic [6:0] r_col;
  logic [3:0] r_glyph;
  logic [5:0] r_row;
  logic [6:0] r_char_col;
  logic [5:0] r_char_row;
  logic [3:0] r_glyph_row;
  logic [2:0] w_cell_x_next;
  logic [6:0] w_col_next;
  logic [3:0] w_glyph_next;
  logic [5:0] w_row_next;

  // Cell coordinates tracked by small modulo counters alongside the raster.
  always_comb begin
    w_cell_x_next = r_cell_x;
    w_col_next    = r_col;
    w_glyph_next  = r_glyph;
    w_row_next    = r_row;
    if (r_pixel_tick) begin
      if (w_h_wrap) begin
        w_cell_x_next = '0;
        w_col_next    = '0;
      end else if (r_cell_x == 3'(CELL_W - 1)) begin
        w_cell_x_next = '0;
        w_col_next    = r_col + 1'b1;
      end else begin
        w_cell_x_next = r_cell_x + 1'b1;
      end
    end
    if (w_h_wrap) begin
      if (w_v_wrap) begin
        w_glyph_next = '0;
        w_row_next   = '0;
      end else if (r_glyph == 4'(CELL_H - 1)) begin
        w_glyph_next = '0;
        w_row_next   = r_row + 1'b1;
      end else begin
        w_glyph_next = r_glyph + 1'b1;
      end
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      r_cell_x    <= '0;
      r_col       <= '0;
      r_glyph     <= '0;
      r_row       <= '0;
      r_char_col  <= '0;
      r_char_row  <= '0;
      r_glyph_row <= '0;
    end else begin
      r_cell_x    <= w_cell_x_next;
      r_col       <= w_col_next;
      r_glyph     <= w_glyph_next;
      r_row       <= w_row_next;
      r_char_col  <= w_video_on_next ? w_col_next   : '0;
      r_char_row  <= w_video_on_next ? w_row_next   : '0;
      r_glyph_row <= w_video_on_next ? w_glyph_next : '0;
    end
  end

  assign char_col  = r_char_col;
  assign char_row  = r_char_row;
  assign glyph_row = r_glyph_row;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen on a reduced raster
//               (48x33 totals) with a cycle-accurate reference scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int HA = 32, HF = 4, HS = 6, HB = 6;
  localparam int VA = 26, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = 2 * HT * VT;

  logic       clock50 = 1'b0;
  logic       reset   = 1'b1;
  logic       pixel_tick;
  logic [9:0] HorizontalCounter;
  logic [9:0] VerticalCounter;
  logic       HSync, VSync, video_on, frame_start;
`ifdef VGA_CHAR_CELL_EN
  logic [6:0] char_col;
  logic [5:0] char_row;
  logic [3:0] glyph_row;
`endif

  always #5 clock50 = ~clock50;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clock50           (clock50),
    .reset             (reset),
    .pixel_tick        (pixel_tick),
    .HorizontalCounter (HorizontalCounter),
    .VerticalCounter   (VerticalCounter),
    .HSync             (HSync),
    .VSync             (VSync),
    .video_on          (video_on),
    .frame_start       (frame_start)
`ifdef VGA_CHAR_CELL_EN
   ,.char_col          (char_col),
    .char_row          (char_row),
    .glyph_row         (glyph_row)
`endif
  );

  typedef struct packed {
    logic       tick;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vid;
    logic       fs;
`ifdef VGA_CHAR_CELL_EN
    logic [6:0] col;
    logic [5:0] row;
    logic [3:0] gly;
`endif
  } obs_t;

  typedef struct {
    int   h;
    int   v;
    logic vid;
    logic hs;
    logic vs;
    logic fs;
  } vec_t;

  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sb_fail  = 0;

  int   m_h = 0, m_v = 0;
  bit   m_tick = 1'b0, m_fs = 1'b0;

  // Reference raster: plain counters with range decodes.
  always @(posedge clock50) begin
    obs_t e;
    if (reset) begin
      m_tick = 1'b0; m_h = 0; m_v = 0; m_fs = 1'b0;
    end else begin
      m_fs = 1'b0;
      if (m_tick) begin
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin m_v = 0; m_fs = 1'b1; end
          else m_v = m_v + 1;
        end else begin
          m_h = m_h + 1;
        end
      end
      m_tick = ~m_tick;
    end
    e.tick = m_tick;
    e.h    = 10'(m_h);
    e.v    = 10'(m_v);
    e.hs   = (m_h >= HA + HF && m_h < HA + HF + HS) ? 1'b0 : 1'b1;
    e.vs   = (m_v >= VA + VF && m_v < VA + VF + VS) ? 1'b0 : 1'b1;
    e.vid  = (m_h < HA) && (m_v < VA);
    e.fs   = m_fs;
`ifdef VGA_CHAR_CELL_EN
    e.col  = e.vid ? 7'(m_h / CELL_W) : 7'd0;
    e.row  = e.vid ? 6'(m_v / CELL_H) : 6'd0;
    e.gly  = e.vid ? 4'(m_v % CELL_H) : 4'd0;
`endif
    sb_q.push_back(e);
  end

  always @(negedge clock50) begin
    obs_t e, a;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a.tick = pixel_tick;
      a.h    = HorizontalCounter;
      a.v    = VerticalCounter;
      a.hs   = HSync;
      a.vs   = VSync;
      a.vid  = video_on;
      a.fs   = frame_start;
`ifdef VGA_CHAR_CELL_EN
      a.col  = char_col;
      a.row  = char_row;
      a.gly  = glyph_row;
`endif
      if (sb_fail < 10) begin
        n_checks++;
        if (a !== e) begin
          n_fail++;
          sb_fail++;
          $display("FAIL scoreboard t=%0t got h=%0d v=%0d tick=%b hs=%b vs=%b vid=%b fs=%b (raw %h) expected h=%0d v=%0d tick=%b hs=%b vs=%b vid=%b fs=%b (raw %h)",
                   $time, a.h, a.v, a.tick, a.hs, a.vs, a.vid, a.fs, a,
                   e.h, e.v, e.tick, e.hs, e.vs, e.vid, e.fs, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_pos(input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(HorizontalCounter == 10'(h) && VerticalCounter == 10'(v))) begin
      @(negedge clock50);
      n++;
      if (n > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_pos timeout at (%0d,%0d): got (%0d,%0d)",
                 h, v, HorizontalCounter, VerticalCounter);
        return;
      end
    end
  endtask

  task automatic wait_fs(input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clock50);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < budget);
    if (frame_start !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL frame_start timeout: got none expected within %0d", budget);
    end
  endtask

  vec_t tbl[14];

  initial begin
    int wrap_n, hs_low, hs_first, vs_low, vs_first, vs_last, gap;

    tbl[0]  = '{HA - 1,           0,           1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{HA,               0,           1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{HA + HF,          0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{HA + HF + HS - 1, 0,           1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{HA + HF + HS,     0,           1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{0,                VA - 1,      1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{HA - 1,           VA - 1,      1'b1, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{HA,               VA - 1,      1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{0,                VA,          1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{0,                VA + VF,     1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{HA + HF,          VA + VF + VS - 1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{0,                VA + VF + VS, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{HT - 1,           VT - 1,      1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{0,                0,           1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b1;
    repeat (5) @(negedge clock50);
    chk("rst_h",      32'(HorizontalCounter), 0);
    chk("rst_v",      32'(VerticalCounter),   0);
    chk("rst_hsync",  32'(HSync),       1);
    chk("rst_vsync",  32'(VSync),       1);
    chk("rst_tick",   32'(pixel_tick),  0);
    chk("rst_fs",     32'(frame_start), 0);
    chk("rst_video",  32'(video_on),    1);
    reset = 1'b0;

    // First line: counter start-up, line wrap time, HSync width and position.
    wrap_n = 0; hs_low = 0; hs_first = -1;
    for (int n = 1; n <= 3 * HT; n++) begin
      @(negedge clock50);
      if (n == 1) chk("h_after_1clk", 32'(HorizontalCounter), 0);
      if (n == 2) chk("h_after_2clk", 32'(HorizontalCounter), 1);
      if (VerticalCounter == 10'd0 && HSync == 1'b0) begin
        if (hs_first < 0) hs_first = int'(HorizontalCounter);
        hs_low++;
      end
      if (VerticalCounter == 10'd1) begin
        wrap_n = n;
        break;
      end
    end
    chk("line_wrap_clks", wrap_n, 2 * HT);
    chk("line_wrap_h",    32'(HorizontalCounter), 0);
    chk("hsync_low_clks", hs_low, 2 * HS);
    chk("hsync_first_h",  hs_first, HA + HF);

    // Frame period and VSync width/position.
    wait_fs(2 * FRAME_CLKS, gap);
    gap = 0; vs_low = 0; vs_first = -1; vs_last = -1;
    do begin
      @(negedge clock50);
      gap++;
      if (VSync == 1'b0) begin
        if (vs_first < 0) vs_first = int'(VerticalCounter);
        vs_last = int'(VerticalCounter);
        vs_low++;
      end
    end while (frame_start !== 1'b1 && gap < 2 * FRAME_CLKS);
    chk("frame_period",   gap, FRAME_CLKS);
    chk("vsync_low_clks", vs_low, 2 * HT * VS);
    chk("vsync_first_v",  vs_first, VA + VF);
    chk("vsync_last_v",   vs_last, VA + VF + VS - 1);

    for (int i = 0; i < 14; i++) begin
      wait_pos(tbl[i].h, tbl[i].v, 2 * FRAME_CLKS);
      chk($sformatf("vec%0d_video", i), 32'(video_on),    32'(tbl[i].vid));
      chk($sformatf("vec%0d_hsync", i), 32'(HSync),       32'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), 32'(VSync),       32'(tbl[i].vs));
      chk($sformatf("vec%0d_fs", i),    32'(frame_start), 32'(tbl[i].fs));
    end

    // One-cycle reset in mid-frame, then a full frame before the next pulse.
    wait_pos(20, 15, 2 * FRAME_CLKS);
    reset = 1'b1;
    @(negedge clock50);
    chk("mid_rst_h",     32'(HorizontalCounter), 0);
    chk("mid_rst_v",     32'(VerticalCounter),   0);
    chk("mid_rst_hsync", 32'(HSync),       1);
    chk("mid_rst_vsync", 32'(VSync),       1);
    chk("mid_rst_tick",  32'(pixel_tick),  0);
    chk("mid_rst_fs",    32'(frame_start), 0);
    chk("mid_rst_video", 32'(video_on),    1);
    reset = 1'b0;
    wait_fs(2 * FRAME_CLKS, gap);
    chk("fs_after_release", gap, FRAME_CLKS);

`ifdef VGA_CHAR_CELL_EN
    wait_pos(8, 12, 2 * FRAME_CLKS);
    chk("cell_8_12_col", 32'(char_col),  1);
    chk("cell_8_12_row", 32'(char_row),  1);
    chk("cell_8_12_gly", 32'(glyph_row), 0);
    wait_pos(HA + 4, 14, 2 * FRAME_CLKS);
    chk("cell_blank_col", 32'(char_col),  0);
    chk("cell_blank_row", 32'(char_row),  0);
    chk("cell_blank_gly", 32'(glyph_row), 0);
    wait_pos(HA - 1, VA - 1, 2 * FRAME_CLKS);
    chk("cell_last_col", 32'(char_col),  (HA - 1) / CELL_W);
    chk("cell_last_row", 32'(char_row),  (VA - 1) / CELL_H);
    chk("cell_last_gly", 32'(glyph_row), (VA - 1) % CELL_H);
`endif

    repeat (4) @(negedge clock50);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
